// File: rtl/dpram_n.sv
// dpram_n: simple dual-port storage array for queue_flags.
// One synchronous write port and one asynchronous read port, so the array
// maps onto distributed RAM. At LOG_DEPTH = 6 each data bit becomes one
// 64-deep dpram64 primitive.
module dpram_n #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LOG_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [LOG_DEPTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store wdata at waddr on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read port is combinational; the queue relies on this for fall-through.
    assign rdata = mem[raddr];
endmodule

// File: rtl/queue_flags.sv
// queue_flags: first-word-fall-through FIFO with occupancy count and status flags.
// The flags come straight from the registered count. ovf and udf are
// registered one-cycle pulses that mark a push or pop that was dropped.
module queue_flags #(
    parameter int WIDTH       = 32,
    parameter int LOG_DEPTH   = 6,
    parameter int AFULL_LEVEL = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic [LOG_DEPTH:0]   count,
    output logic                 ovf,
    output logic                 udf
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] AFULL_CNT = (LOG_DEPTH+1)'(AFULL_LEVEL);

    // Reject illegal parameter combinations when the design is elaborated.
    if (WIDTH < 1) begin : g_bad_width
        $error("queue_flags: WIDTH must be at least 1");
    end
    if (LOG_DEPTH < 2 || LOG_DEPTH > 10) begin : g_bad_log_depth
        $error("queue_flags: LOG_DEPTH must be in 2..10");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("queue_flags: AFULL_LEVEL must be in 1..DEPTH");
    end

    logic [LOG_DEPTH-1:0] ra;
    logic [LOG_DEPTH-1:0] wa;
    logic                 push;
    logic                 pop;

    // When the queue is full, a simultaneous pop frees a slot, so the push is
    // still accepted. Both requests are ignored while rst is high.
    assign push = !rst && wr_en && (!full || rd_en);
    assign pop  = !rst && rd_en && !empty;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_CNT);
    assign almost_full = (count >= AFULL_CNT);

    dpram_n #(
        .WIDTH     (WIDTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wa),
        .wdata (din),
        .raddr (ra),
        .rdata (dout)
    );

    // Advance the pointers and count, and register the drop pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            wa    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (push) begin
                wa <= wa + 1'b1;
            end
            if (pop) begin
                ra <= ra + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            ovf <= wr_en && !push;
            udf <= rd_en && !pop;
        end
    end
endmodule

// File: tb/tb_queue_flags.sv
// tb_queue_flags: self-checking bench for queue_flags at the default parameters.
// A queue-based reference model is driven from the push/pop rules. A short
// table of hand-computed vectors covers the empty-queue corners.
module tb_queue_flags;
    localparam int WIDTH = 32;
    localparam int LOG_DEPTH = 6;
    localparam int DEPTH = 64;
    localparam int AFULL = 60;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [LOG_DEPTH:0] count;
    logic             ovf;
    logic             udf;

    queue_flags #(.WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .almost_full(almost_full),
        .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [WIDTH-1:0] q[$];
    logic exp_ovf;
    logic exp_udf;
    int   dead_pops;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] d;
        int          e_count;
        logic        e_empty;
        logic [31:0] e_dout;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, and sample #1 after the edge.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        pop_ok  = r && (q.size() > 0);
        push_ok = w && (q.size() < DEPTH || r);
        @(posedge clk);
        if (pop_ok) begin
            if (dout == 32'hDEAD) dead_pops++;
            void'(q.pop_front());
        end
        if (push_ok) q.push_back(d);
        exp_ovf = w && !push_ok;
        exp_udf = r && !pop_ok;
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= AFULL));
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(exp_udf));
        if (q.size() > 0) chk({tag, ".dout"}, dout, q[0]);
    endtask

    task automatic do_reset(input logic w, input logic r);
        @(negedge clk);
        rst = 1'b1;
        wr_en = w;
        rd_en = r;
        din = 32'h1234_5678;
        @(posedge clk);
        #1;
        q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.afull", 32'(almost_full), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.udf", 32'(udf), 32'd0);
        @(posedge clk);
        #1;
        chk("rst2.count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        dead_pops = 0;

        // Hand-computed vectors, starting from an empty queue.
        tbl[0] = '{1'b1, 1'b0, 32'hA5A5_0001, 1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0007, 1, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h0,         1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h0,         1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 32'h0,         0, 1'b1, 32'h0,         1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0007, 1, 1'b0, 32'h0000_0007, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h0,         0, 1'b1, 32'h0,         1'b0, 1'b0};

        do_reset(1'b1, 1'b1);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d.ovf", i), 32'(ovf), 32'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d.udf", i), 32'(udf), 32'(tbl[i].e_udf));
            if (!tbl[i].e_empty) chk($sformatf("tbl%0d.dout", i), dout, tbl[i].e_dout);
        end

        // Fill with 0..63 and watch the almost_full and full thresholds.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 32'(i));
            chk("fill.afull", 32'(almost_full), 32'(i + 1 >= AFULL));
            chk("fill.full", 32'(full), 32'(i + 1 == DEPTH));
            check_model("fill");
        end

        // A push into the full queue is dropped and ovf pulses for one cycle.
        step(1'b1, 1'b0, 32'hDEAD);
        chk("ovf.pulse", 32'(ovf), 32'd1);
        chk("ovf.count", 32'(count), 32'd64);
        check_model("ovf");
        step(1'b0, 1'b0, 32'h0);
        chk("ovf.clear", 32'(ovf), 32'd0);

        // Push and pop together while full: both are accepted.
        step(1'b1, 1'b1, 32'hBEEF);
        chk("fullrw.count", 32'(count), 32'd64);
        chk("fullrw.ovf", 32'(ovf), 32'd0);
        check_model("fullrw");

        // Drain the queue. The model holds 1..63 followed by BEEF.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("drain.beef", dout, 32'hBEEF);
            else                chk("drain.seq", dout, 32'(i + 1));
            step(1'b0, 1'b1, 32'h0);
            check_model("drain");
        end
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.nodead", 32'(dead_pops), 32'd0);

        // Random traffic with a reset in the middle of the stream.
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic r;
            if (i == 150) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if (i < 100 || (i >= 250 && i < 330)) begin
                w = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < 30);
            end else begin
                w = ($urandom_range(0, 99) < 45);
                r = ($urandom_range(0, 99) < 55);
            end
            step(w, r, $urandom);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
